// File: rtl/score_ctrl.sv
// Two-player score keeper with saturating counters, high-score tracking and a
// time-multiplexed 4-digit display scanner (active-low digit enables).
module score_ctrl #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned MAX_SCORE = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       hit1,
  input  logic       hit2,
  input  logic       miss,
  input  logic       show_hs,
  input  logic [3:0] p1,
  input  logic [3:0] p2,
  input  logic [3:0] p3,
  input  logic [3:0] p4,
  input  logic [3:0] h1,
  input  logic [3:0] h2,
  output logic [6:0] counter,
  output logic [6:0] counter2,
  output logic [6:0] hs,
  output logic       playing,
  output logic       game_over,
  output logic [3:0] an,
  output logic [3:0] digit
);

  localparam int unsigned SW = 7;
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   cnt1_q, cnt1_d;
  logic [SW-1:0]   cnt2_q, cnt2_d;
  logic [SW-1:0]   hs_q, hs_d;
  logic [SW-1:0]   best_c;
  logic            playing_q, game_over_q;
  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      slot_q, slot_d;
  logic [DW-1:0]   an_q, an_d;
  logic [DW-1:0]   digit_q, digit_d;

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v >= SW'(MAX_SCORE)) ? v : v + SW'(1);
  endfunction

  // Game FSM and score datapath; hits landing with miss count before hs update.
  always_comb begin
    state_d = state_q;
    cnt1_d  = cnt1_q;
    cnt2_d  = cnt2_q;
    hs_d    = hs_q;
    best_c  = hs_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d = S_PLAY;
          cnt1_d  = '0;
          cnt2_d  = '0;
        end
      end
      S_PLAY: begin
        if (hit1) cnt1_d = sat_inc(cnt1_q);
        if (hit2) cnt2_d = sat_inc(cnt2_q);
        if (miss) begin
          state_d = S_OVER;
          if (cnt1_d > best_c) best_c = cnt1_d;
          if (cnt2_d > best_c) best_c = cnt2_d;
          hs_d = best_c;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Display scanner: free-running prescaler steps the slot; an/digit lag by one cycle.
  always_comb begin
    presc_d = presc_q + PW'(1);
    slot_d  = slot_q;
    an_d    = 4'b1111;
    digit_d = '0;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      slot_d  = slot_q + 2'd1;
    end
    case (slot_q)
      2'd0: begin
        an_d    = 4'b1110;
        digit_d = show_hs ? h1 : p1;
      end
      2'd1: begin
        an_d    = 4'b1101;
        digit_d = show_hs ? h2 : p2;
      end
      2'd2: begin
        an_d    = show_hs ? 4'b1111 : 4'b1011;
        digit_d = show_hs ? '0 : p3;
      end
      default: begin
        an_d    = show_hs ? 4'b1111 : 4'b0111;
        digit_d = show_hs ? '0 : p4;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
      hs_q        <= '0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
      presc_q     <= '0;
      slot_q      <= '0;
      an_q        <= 4'b1111;
      digit_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
      hs_q        <= hs_d;
      playing_q   <= (state_d == S_PLAY);
      game_over_q <= (state_d == S_OVER);
      presc_q     <= presc_d;
      slot_q      <= slot_d;
      an_q        <= an_d;
      digit_q     <= digit_d;
    end
  end

  assign counter   = cnt1_q;
  assign counter2  = cnt2_q;
  assign hs        = hs_q;
  assign playing   = playing_q;
  assign game_over = game_over_q;
  assign an        = an_q;
  assign digit     = digit_q;

endmodule
